fix2flt_unit: RTL and testbench
===============================

// Module: fix2flt_unit
// PURPOSE
//  Sequential hardware converter from signed 8.8 fixed point to IEEE-754 half float.
//  It is the consumer of the flt2fix result: on Start it reads the 16-bit 8.8 word from data
//  memory, normalises it with an iterative shifter and writes the half-float back to memory.
//  It is a byte-wide memory master beside the core and uses the same Start/Done handshake as Top.
//  Truncation only, no rounding. Its output is never subnormal, Inf or NaN.
// PARAMETERS
//  ADDR_W    8  width of data-memory byte address
//  SRC_ADDR  6  address of the fixed-point low byte; the high byte is at SRC_ADDR+1
//  DST_ADDR  8  address of the float low byte; the high byte is at DST_ADDR+1
// PORTS
//  Clk        in   1       single clock; all state changes on its rising edge
//  Reset      in   1       synchronous, active-high; returns the unit to IDLE
//  Start      in   1       request; sampled only in IDLE
//  Done       out  1       conversion complete; held high in DONE
//  Busy       out  1       high in every state except IDLE and DONE
//  MemAddr    out  ADDR_W  byte address for the read or write
//  MemWrEn    out  1       write strobe; memory captures MemWrData at the clock edge
//  MemWrData  out  8       write byte
//  MemRdData  in   8       combinational read data for MemAddr in the same cycle
// BEHAVIOUR
//  Reset: state=IDLE, Done=0, Busy=0, MemWrEn=0, MemAddr=0, MemWrData=0, datapath regs=0.
//   Reset mid-operation aborts immediately and issues no further writes.
//   Bytes already written stay in memory.
//  FSM (one state per cycle unless noted):
//   IDLE:  if Start, go to RD_LO and clear Done.
//   DONE:  Done=1. Start goes to RD_LO (Done drops); otherwise stay in DONE.
//   RD_LO: MemAddr=SRC_ADDR; latch lo=MemRdData.
//   RD_HI: MemAddr=SRC_ADDR+1; latch hi=MemRdData.
//   ABS:   sign=x[15] where x={hi,lo}; mag = sign ? -x : x (16-bit unsigned, so 0x8000 gives 0x8000).
//          zero=(x==0). Clear the shift counter s.
//   NORM:  if zero or mag[15]: go to WR_LO. Else mag<<=1, s++ and stay in NORM (max 15 shifts).
//   WR_LO: MemAddr=DST_ADDR, MemWrEn=1, MemWrData=f[7:0].
//   WR_HI: MemAddr=DST_ADDR+1, MemWrEn=1, MemWrData=f[15:8], then go to DONE.
//  Packing:
//   f = zero ? 16'h0000 : {sign, 5'(22-s), mag[14:5]}.
//   The exponent range is 7..22 (value = mag/256), so it never saturates.
//   mag[4:0] is discarded (truncation).
//  Latency: Done rises 6+s cycles after the Clk edge that samples Start (zero input: s=0).
//   The minimum is 6 and the maximum is 21.
//  Start in any non-IDLE, non-DONE state is ignored. The operation is not restarted.
//  MemWrEn is asserted only in WR_LO and WR_HI. In all other states MemWrEn=0 and MemWrData=0.
//  SRC_ADDR+1 and DST_ADDR+1 wrap modulo 2**ADDR_W.
// TESTING
//  The bench supplies a byte memory model and loads {mem[7],mem[6]} before each Start pulse.
//  Every case checks {mem[9],mem[8]}, the Done cycle, and that exactly two writes occur.
//  1) 0x0100 (1.0) -> 0x3C00, Done at cycle 13; 0x0180 (1.5) -> 0x3E00.
//  2) 0xFF00 (-1.0) -> 0xBC00; 0x8000 (-128.0) -> 0xD800, Done at cycle 6.
//  3) 0x7FFF -> 0x57FF (truncated, not rounded); 0x0001 -> 0x1C00, Done at cycle 21.
//  4) 0x0000 -> 0x0000, Done at cycle 6.
//  5) Start pulsed during NORM is ignored (one result, unchanged latency).
//     Back-to-back Start from DONE converts the new word.
//  6) Reset asserted during NORM -> IDLE next cycle, no writes, Done=0, destination unchanged.

Source files
------------

// File: rtl/fix2flt_unit.sv
// Sequential signed 8.8 fixed-point to IEEE-754 half-float converter.
// Reads the source word from byte memory, normalises iteratively and writes the half back.
module fix2flt_unit #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] SRC_ADDR = ADDR_W'(6),
  parameter logic [ADDR_W-1:0] DST_ADDR = ADDR_W'(8)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic              Done,
  output logic              Busy,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemWrEn,
  output logic [7:0]        MemWrData,
  input  logic [7:0]        MemRdData
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_LO = 3'd1,
    S_RD_HI = 3'd2,
    S_ABS   = 3'd3,
    S_NORM  = 3'd4,
    S_WR_LO = 3'd5,
    S_WR_HI = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] SRC_HI   = SRC_ADDR + ADDR_ONE;
  localparam logic [ADDR_W-1:0] DST_HI   = DST_ADDR + ADDR_ONE;

  state_t            r_state;
  logic [7:0]        r_lo;
  logic [7:0]        r_hi;
  logic              r_sign;
  logic              r_zero;
  logic [15:0]       r_mag;
  logic [3:0]        r_shift;
  logic              r_done;
  logic              r_busy;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_wr_en;
  logic [7:0]        r_wr_data;

  logic [15:0] w_x;
  logic [15:0] w_neg;
  logic [15:0] w_f;

  // Exponent is 22 minus the shift count, so a normalised magnitude never over/underflows.
  function automatic logic [15:0] pack_half(input logic        sign,
                                            input logic        zero,
                                            input logic [15:0] mag,
                                            input logic [3:0]  s);
    logic [4:0] exp_v;
    exp_v = 5'd22 - {1'b0, s};
    if (zero) begin
      return 16'h0000;
    end else begin
      return {sign, exp_v, mag[14:5]};
    end
  endfunction

  // Datapath combinational helpers: source word, its negation and the packed result.
  always_comb begin
    w_x   = {r_hi, r_lo};
    w_neg = 16'd0 - w_x;
    w_f   = pack_half(r_sign, r_zero, r_mag, r_shift);
  end

  // Control FSM with registered memory-bus and handshake outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_lo       <= 8'd0;
      r_hi       <= 8'd0;
      r_sign     <= 1'b0;
      r_zero     <= 1'b0;
      r_mag      <= 16'd0;
      r_shift    <= 4'd0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_mem_addr <= '0;
      r_wr_en    <= 1'b0;
      r_wr_data  <= 8'd0;
    end else begin
      r_mem_addr <= '0;
      r_wr_en    <= 1'b0;
      r_wr_data  <= 8'd0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            r_state    <= S_RD_LO;
            r_done     <= 1'b0;
            r_busy     <= 1'b1;
            r_mem_addr <= SRC_ADDR;
          end else begin
            r_state <= r_state;
          end
        end
        S_RD_LO: begin
          r_lo       <= MemRdData;
          r_mem_addr <= SRC_HI;
          r_state    <= S_RD_HI;
        end
        S_RD_HI: begin
          r_hi    <= MemRdData;
          r_state <= S_ABS;
        end
        S_ABS: begin
          // Unsigned 16-bit magnitude: 0x8000 negates to itself, which is the right value.
          r_sign  <= w_x[15];
          r_mag   <= w_x[15] ? w_neg : w_x;
          r_zero  <= (w_x == 16'd0);
          r_shift <= 4'd0;
          r_state <= S_NORM;
        end
        S_NORM: begin
          if (r_zero || r_mag[15]) begin
            r_state    <= S_WR_LO;
            r_mem_addr <= DST_ADDR;
            r_wr_en    <= 1'b1;
            r_wr_data  <= w_f[7:0];
          end else begin
            r_mag   <= {r_mag[14:0], 1'b0};
            r_shift <= r_shift + 4'd1;
          end
        end
        S_WR_LO: begin
          r_state    <= S_WR_HI;
          r_mem_addr <= DST_HI;
          r_wr_en    <= 1'b1;
          r_wr_data  <= w_f[15:8];
        end
        S_WR_HI: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Done      = r_done;
  assign Busy      = r_busy;
  assign MemAddr   = r_mem_addr;
  assign MemWrEn   = r_wr_en;
  assign MemWrData = r_wr_data;

endmodule

// File: tb/tb_fix2flt_unit.sv
// Bench for fix2flt_unit: byte memory model, directed vector table, corner sequences
// and random words checked against an arithmetic half-float reference.
module tb_fix2flt_unit;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic       Done;
  logic       Busy;
  logic [7:0] MemAddr;
  logic       MemWrEn;
  logic [7:0] MemWrData;
  logic [7:0] MemRdData;

  fix2flt_unit #(.ADDR_W(8), .SRC_ADDR(8'd6), .DST_ADDR(8'd8)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Done(Done), .Busy(Busy),
    .MemAddr(MemAddr), .MemWrEn(MemWrEn), .MemWrData(MemWrData), .MemRdData(MemRdData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [7:0]  mem [0:255];
  logic        ld_en;
  logic [15:0] ld_src;
  logic [15:0] ld_dst;
  int          wr_cnt;
  int          stray_cnt;

  int n_checks;
  int n_errors;

  assign MemRdData = mem[MemAddr];

  // Memory model: bench loads and DUT writes share one process.
  always @(posedge Clk) begin
    if (ld_en) begin
      mem[6]    <= ld_src[7:0];
      mem[7]    <= ld_src[15:8];
      mem[8]    <= ld_dst[7:0];
      mem[9]    <= ld_dst[15:8];
      wr_cnt    <= 0;
      stray_cnt <= 0;
    end else begin
      if (MemWrEn) begin
        mem[MemAddr] <= MemWrData;
        wr_cnt       <= wr_cnt + 1;
        if (MemAddr != 8'd8 && MemAddr != 8'd9) stray_cnt <= stray_cnt + 1;
      end else if (MemWrData != 8'd0) begin
        stray_cnt <= stray_cnt + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Reference: half-float from the real value |x|/256 with a truncated 10-bit fraction.
  function automatic void model(input logic [15:0] x, output logic [15:0] f, output int cyc);
    int   v, mag, e, mant;
    logic sgn;
    v   = int'($signed(x));
    sgn = (v < 0);
    mag = sgn ? -v : v;
    if (mag == 0) begin
      f   = 16'h0000;
      cyc = 6;
    end else begin
      e = 0;
      while ((1 << (e + 1)) <= mag) e++;
      mant = (mag * 1024) / (1 << e) - 1024;
      f    = {sgn, 5'(e + 7), 10'(mant)};
      cyc  = 6 + (15 - e);
    end
  endfunction

  task automatic load(input logic [15:0] src, input logic [15:0] dst);
    @(negedge Clk);
    ld_src = src;
    ld_dst = dst;
    ld_en  = 1'b1;
    @(negedge Clk);
    ld_en  = 1'b0;
  endtask

  // One conversion; glitch_at > 0 pulses Start for one cycle at that cycle number.
  task automatic run(input string name, input logic [15:0] x, input logic [15:0] exp_f,
                     input int exp_cyc, input int glitch_at);
    int  cyc;
    bit  seen;
    load(x, 16'hA5A5);
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    check({name, "_done_drop"}, {31'd0, Done}, 32'd0);
    seen = 1'b0;
    cyc  = 0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(posedge Clk);
      #1;
      Start = (n == glitch_at);
      if (n == 3) check({name, "_busy"}, {31'd0, Busy}, 32'd1);
      if (Done) begin
        seen = 1'b1;
        cyc  = n;
      end
    end
    Start = 1'b0;
    check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
    check({name, "_cycle"}, cyc, exp_cyc);
    check({name, "_result"}, {16'd0, mem[9], mem[8]}, {16'd0, exp_f});
    check({name, "_writes"}, wr_cnt, 32'd2);
    check({name, "_stray"}, stray_cnt, 32'd0);
    check({name, "_busy_done"}, {31'd0, Busy}, 32'd0);
  endtask

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] f;
    int          cyc;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [15:0] rx, rf;
    int          rc;

    vecs[0] = '{x: 16'h0100, f: 16'h3C00, cyc: 13};
    vecs[1] = '{x: 16'h0180, f: 16'h3E00, cyc: 13};
    vecs[2] = '{x: 16'hFF00, f: 16'hBC00, cyc: 13};
    vecs[3] = '{x: 16'h8000, f: 16'hD800, cyc: 6};
    vecs[4] = '{x: 16'h7FFF, f: 16'h57FF, cyc: 7};
    vecs[5] = '{x: 16'h0001, f: 16'h1C00, cyc: 21};
    vecs[6] = '{x: 16'h0000, f: 16'h0000, cyc: 6};

    n_checks = 0;
    n_errors = 0;
    Reset    = 1'b1;
    Start    = 1'b0;
    ld_en    = 1'b0;
    ld_src   = 16'd0;
    ld_dst   = 16'd0;
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_done",  {31'd0, Done},    32'd0);
    check("rst_busy",  {31'd0, Busy},    32'd0);
    check("rst_wren",  {31'd0, MemWrEn}, 32'd0);
    check("rst_addr",  {24'd0, MemAddr}, 32'd0);
    check("rst_wdata", {24'd0, MemWrData}, 32'd0);
    Reset = 1'b0;

    // Directed table, applied back to back (each later Start comes from DONE).
    for (int i = 0; i < 7; i++) begin
      run($sformatf("vec%0d", i), vecs[i].x, vecs[i].f, vecs[i].cyc, 0);
      model(vecs[i].x, rf, rc);
      check($sformatf("model%0d", i), {16'd0, rf}, {16'd0, vecs[i].f});
    end

    // Start pulsed during NORM must not disturb the running conversion.
    run("glitch", 16'h0001, 16'h1C00, 21, 8);

    // Reset during NORM aborts with no writes and leaves the destination alone.
    load(16'h0001, 16'h5A5A);
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    repeat (8) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk);
    #1;
    check("abort_done", {31'd0, Done},    32'd0);
    check("abort_busy", {31'd0, Busy},    32'd0);
    check("abort_wren", {31'd0, MemWrEn}, 32'd0);
    Reset = 1'b0;
    repeat (25) @(posedge Clk);
    #1;
    check("abort_writes", wr_cnt, 32'd0);
    check("abort_dst", {16'd0, mem[9], mem[8]}, 32'h0000_5A5A);
    check("abort_idle_done", {31'd0, Done}, 32'd0);

    // Random words against the arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      rx = 16'($urandom);
      if (i % 8 == 0) rx = rx >> (i / 8 + 7);
      model(rx, rf, rc);
      run($sformatf("rnd%0d_%h", i, rx), rx, rf, rc, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
